// File: rtl/regbus_arb_if.sv
// Register bus bundle: SPI port, local master port and target port.
// slave = arbiter side, master = environment side (SPI, master, target).
interface regbus_arb_if;
   logic        s_active;
   logic        s_we;
   logic [6:0]  s_addr;
   logic [31:0] s_wdat;
   logic [31:0] s_rdat;
   logic        m_req;
   logic        m_we;
   logic [6:0]  m_addr;
   logic [31:0] m_wdat;
   logic        m_ack;
   logic [31:0] m_rdat;
   logic        t_we;
   logic [6:0]  t_addr;
   logic [31:0] t_wdat;
   logic [31:0] t_rdat;

   modport slave (
      input  s_active, s_we, s_addr, s_wdat,
      output s_rdat,
      input  m_req, m_we, m_addr, m_wdat,
      output m_ack, m_rdat,
      output t_we, t_addr, t_wdat,
      input  t_rdat
   );

   modport master (
      output s_active, s_we, s_addr, s_wdat,
      input  s_rdat,
      output m_req, m_we, m_addr, m_wdat,
      input  m_ack, m_rdat,
      input  t_we, t_addr, t_wdat,
      output t_rdat
   );
endinterface

// File: rtl/regbus_arb.sv
// Arbiter sharing one register target between an SPI slave and a local master.
// Ports: clk, rst_n, bus (slave modport), spi_own (SPI owns bus), coll_cnt.
module regbus_arb #(
   parameter int TAIL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   regbus_arb_if.slave bus,
   output logic       spi_own,
   output logic [7:0] coll_cnt
);

   localparam int TW = (TAIL < 2) ? 1 : $clog2(TAIL + 1);

   typedef enum logic [1:0] {
      IDLE,
      SPI,
      MST,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [TW-1:0] tail;
   logic [TW-1:0] tail_nx;
   logic        act;
   logic        sel_m;
   logic        coll;
   logic        cap;
   logic [31:0] rdat;

   assign act   = bus.s_active | bus.s_we;
   // SPI writes always win the target, even in the master's cycle
   assign sel_m = (state == MST) & ~bus.s_we;

   assign bus.t_addr = sel_m ? bus.m_addr : bus.s_addr;
   assign bus.t_wdat = sel_m ? bus.m_wdat : bus.s_wdat;
   assign bus.t_we   = sel_m ? bus.m_we   : bus.s_we;
   assign bus.s_rdat = bus.t_rdat;
   assign bus.m_ack  = (state == DONE);
   assign bus.m_rdat = rdat;
   assign spi_own    = (state == SPI);

   always_comb begin
      state_nx = state;
      coll     = 1'b0;
      cap      = 1'b0;
      unique case (state)
         IDLE: begin
            if (act)
               state_nx = SPI;
            else if (bus.m_req)
               state_nx = MST;
         end
         SPI: begin
            if (!act && tail == '0)
               state_nx = IDLE;
         end
         MST: begin
            if (bus.s_we) begin
               state_nx = SPI;
               coll     = 1'b1;
            end else begin
               state_nx = DONE;
               cap      = 1'b1;
            end
         end
         DONE: begin
            state_nx = act ? SPI : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Tail keeps SPI ownership across the late write strobe after CS release
   always_comb begin
      tail_nx = tail;
      if (act)
         tail_nx = TAIL[TW-1:0];
      else if (tail != '0)
         tail_nx = tail - TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tail     <= '0;
         rdat     <= '0;
         coll_cnt <= '0;
      end else begin
         state <= state_nx;
         tail  <= tail_nx;
         if (cap)
            rdat <= bus.t_rdat;
         if (coll && coll_cnt != 8'hFF)
            coll_cnt <= coll_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_regbus_arb.sv
// Self-checking bench for regbus_arb: directed table, corner sequences, random.
// Drives the bus interface, emulates the target memory, compares to a model.
module tb_regbus_arb;

   localparam int TAIL = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_own;
   logic [7:0] coll_cnt;

   regbus_arb_if bus();

   regbus_arb #(.TAIL(TAIL)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .spi_own (spi_own),
      .coll_cnt(coll_cnt)
   );

   always #5 clk = ~clk;

   logic [31:0] tmem [128];
   assign bus.t_rdat = tmem[bus.t_addr];

   int nvec = 0;
   int nbad = 0;

   // behavioural model: ownership flag + quiet count, master phase
   bit          md_spi;
   int          md_quiet;
   int          md_phase;
   logic [31:0] md_rd;
   int          md_coll;
   logic [31:0] mmem [128];

   logic [6:0]  sm_taddr;
   logic        sm_twe;
   logic [31:0] sm_twdat;
   logic        sm_ack;
   logic [31:0] sm_rdat;
   logic        sm_own;
   logic [7:0]  sm_coll;

   typedef struct {
      logic        sa;
      logic        sw;
      logic [6:0]  saddr;
      logic [31:0] swdat;
      logic        mr;
      logic        mw;
      logic [6:0]  maddr;
      logic [31:0] mwdat;
      logic [6:0]  taddr;
      logic        twe;
      logic [31:0] twdat;
      logic        ack;
      logic [31:0] rdat;
      logic        own;
      logic [7:0]  coll;
   } vec_t;

   vec_t tab [20];

   task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic timeout(string nm);
      nvec++;
      nbad++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   task automatic model_reset();
      md_spi   = 1'b0;
      md_quiet = 0;
      md_phase = 0;
      md_rd    = '0;
      md_coll  = 0;
   endtask

   // one clock: compare at negedge, advance model, step edge, emulate target write
   task automatic cycle();
      logic        sel;
      logic [6:0]  ea;
      logic        ew;
      logic [31:0] ed;
      logic        act;
      logic        wr;
      logic [6:0]  wa;
      logic [31:0] wd;
      @(negedge clk);
      sel = (md_phase == 1) && !bus.s_we;
      ea  = sel ? bus.m_addr : bus.s_addr;
      ew  = sel ? bus.m_we : bus.s_we;
      ed  = sel ? bus.m_wdat : bus.s_wdat;
      sm_taddr = bus.t_addr;
      sm_twe   = bus.t_we;
      sm_twdat = bus.t_wdat;
      sm_ack   = bus.m_ack;
      sm_rdat  = bus.m_rdat;
      sm_own   = spi_own;
      sm_coll  = coll_cnt;
      chk("t_addr", 32'(bus.t_addr), 32'(ea));
      chk("t_we", 32'(bus.t_we), 32'(ew));
      chk("t_wdat", bus.t_wdat, ed);
      chk("s_rdat", bus.s_rdat, mmem[ea]);
      chk("m_ack", 32'(bus.m_ack), 32'(md_phase == 2));
      chk("m_rdat", bus.m_rdat, md_rd);
      chk("spi_own", 32'(spi_own), 32'(md_spi));
      chk("coll_cnt", 32'(coll_cnt), 32'(md_coll));
      wr = bus.t_we;
      wa = bus.t_addr;
      wd = bus.t_wdat;
      act = bus.s_active | bus.s_we;
      if (md_spi) begin
         if (act)
            md_quiet = 0;
         else if (md_quiet == TAIL)
            md_spi = 1'b0;
         else
            md_quiet++;
      end else if (md_phase == 1) begin
         if (bus.s_we) begin
            md_coll  = (md_coll < 255) ? md_coll + 1 : 255;
            md_spi   = 1'b1;
            md_quiet = 0;
            md_phase = 0;
         end else begin
            md_rd    = mmem[bus.m_addr];
            md_phase = 2;
         end
      end else if (md_phase == 2) begin
         md_phase = 0;
         if (act) begin
            md_spi   = 1'b1;
            md_quiet = 0;
         end
      end else begin
         if (act) begin
            md_spi   = 1'b1;
            md_quiet = 0;
         end else if (bus.m_req) begin
            md_phase = 1;
         end
      end
      if (ew)
         mmem[ea] = ed;
      @(posedge clk);
      #1;
      if (wr)
         tmem[wa] = wd;
   endtask

   initial begin
      int n;
      int w;
      bit ok;

      tab[0]  = '{0,0,7'h33,0, 0,0,7'h00,0,          7'h33,0,0,          0,0,            0,0};
      tab[1]  = '{0,0,7'h33,0, 1,0,7'h05,0,          7'h33,0,0,          0,0,            0,0};
      tab[2]  = '{0,0,7'h33,0, 1,0,7'h05,0,          7'h05,0,0,          0,0,            0,0};
      tab[3]  = '{0,0,7'h33,0, 0,0,7'h05,0,          7'h33,0,0,          1,32'hDEADBEEF, 0,0};
      tab[4]  = '{0,0,7'h33,0, 1,1,7'h10,32'h12345678, 7'h33,0,0,        0,32'hDEADBEEF, 0,0};
      tab[5]  = '{0,0,7'h33,0, 1,1,7'h10,32'h12345678, 7'h10,1,32'h12345678, 0,32'hDEADBEEF, 0,0};
      tab[6]  = '{0,0,7'h33,0, 0,1,7'h10,32'h12345678, 7'h33,0,0,        1,32'hC0DE0010, 0,0};
      tab[7]  = '{0,0,7'h33,0, 1,0,7'h10,0,          7'h33,0,0,          0,32'hC0DE0010, 0,0};
      tab[8]  = '{0,0,7'h33,0, 1,0,7'h10,0,          7'h10,0,0,          0,32'hC0DE0010, 0,0};
      tab[9]  = '{0,0,7'h33,0, 0,0,7'h10,0,          7'h33,0,0,          1,32'h12345678, 0,0};
      tab[10] = '{0,0,7'h33,0, 1,0,7'h05,0,          7'h33,0,0,          0,32'h12345678, 0,0};
      tab[11] = '{0,1,7'h02,32'hA5A5A5A5, 1,0,7'h05,0, 7'h02,1,32'hA5A5A5A5, 0,32'h12345678, 0,0};
      tab[12] = '{0,0,7'h02,0, 1,0,7'h05,0,          7'h02,0,0,          0,32'h12345678, 1,1};
      tab[13] = '{0,0,7'h02,0, 1,0,7'h05,0,          7'h02,0,0,          0,32'h12345678, 1,1};
      tab[14] = '{0,0,7'h02,0, 1,0,7'h05,0,          7'h02,0,0,          0,32'h12345678, 1,1};
      tab[15] = '{0,0,7'h02,0, 1,0,7'h05,0,          7'h02,0,0,          0,32'h12345678, 1,1};
      tab[16] = '{0,0,7'h02,0, 1,0,7'h05,0,          7'h02,0,0,          0,32'h12345678, 1,1};
      tab[17] = '{0,0,7'h02,0, 1,0,7'h05,0,          7'h02,0,0,          0,32'h12345678, 0,1};
      tab[18] = '{0,0,7'h02,0, 1,0,7'h05,0,          7'h05,0,0,          0,32'h12345678, 0,1};
      tab[19] = '{0,0,7'h02,0, 0,0,7'h05,0,          7'h02,0,0,          1,32'hDEADBEEF, 0,1};

      for (int i = 0; i < 128; i++) begin
         tmem[i] = 32'hC0DE0000 | 32'(i);
         mmem[i] = 32'hC0DE0000 | 32'(i);
      end
      tmem[5] = 32'hDEADBEEF;
      mmem[5] = 32'hDEADBEEF;

      rst_n        = 1'b0;
      bus.s_active = 1'b0;
      bus.s_we     = 1'b0;
      bus.s_addr   = '0;
      bus.s_wdat   = '0;
      bus.m_req    = 1'b0;
      bus.m_we     = 1'b0;
      bus.m_addr   = '0;
      bus.m_wdat   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(bus.m_ack), 0);
      chk("rst_rdat", bus.m_rdat, 0);
      chk("rst_own", 32'(spi_own), 0);
      chk("rst_coll", 32'(coll_cnt), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         bus.s_active = tab[i].sa;
         bus.s_we     = tab[i].sw;
         bus.s_addr   = tab[i].saddr;
         bus.s_wdat   = tab[i].swdat;
         bus.m_req    = tab[i].mr;
         bus.m_we     = tab[i].mw;
         bus.m_addr   = tab[i].maddr;
         bus.m_wdat   = tab[i].mwdat;
         cycle();
         chk($sformatf("tab%0d_taddr", i), 32'(sm_taddr), 32'(tab[i].taddr));
         chk($sformatf("tab%0d_twe", i), 32'(sm_twe), 32'(tab[i].twe));
         chk($sformatf("tab%0d_twdat", i), sm_twdat, tab[i].twdat);
         chk($sformatf("tab%0d_ack", i), 32'(sm_ack), 32'(tab[i].ack));
         chk($sformatf("tab%0d_rdat", i), sm_rdat, tab[i].rdat);
         chk($sformatf("tab%0d_own", i), 32'(sm_own), 32'(tab[i].own));
         chk($sformatf("tab%0d_coll", i), 32'(sm_coll), 32'(tab[i].coll));
      end

      // late SPI write strobe inside the tail
      bus.m_req    = 1'b0;
      bus.s_active = 1'b1;
      bus.s_addr   = 7'h20;
      bus.s_wdat   = '0;
      cycle();
      chk("tail_own_first", 32'(sm_own), 0);
      cycle();
      chk("tail_own_act", 32'(sm_own), 1);
      cycle();
      bus.s_active = 1'b0;
      cycle();
      cycle();
      chk("tail_own_quiet", 32'(sm_own), 1);
      bus.s_we   = 1'b1;
      bus.s_wdat = 32'h0BADF00D;
      cycle();
      chk("tail_twe", 32'(sm_twe), 1);
      chk("tail_taddr", 32'(sm_taddr), 32'h20);
      chk("tail_twdat", sm_twdat, 32'h0BADF00D);
      chk("tail_own_we", 32'(sm_own), 1);
      bus.s_we = 1'b0;
      n = 0;
      do begin
         cycle();
         if (sm_own)
            n++;
      end while (sm_own && n < 20);
      chk("tail_len", 32'(n), 32'(TAIL + 1));
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 7'h20;
      cycle();
      cycle();
      bus.m_req = 1'b0;
      cycle();
      chk("tail_rd_ack", 32'(sm_ack), 1);
      chk("tail_rd_dat", sm_rdat, 32'h0BADF00D);

      // 300 collisions on top of the one from the table
      bus.m_addr = 7'h05;
      for (int k = 0; k < 300; k++) begin
         bus.m_req = 1'b1;
         bus.s_we  = 1'b0;
         w = 0;
         while (md_phase != 1 && w < 30) begin
            cycle();
            w++;
         end
         if (md_phase != 1) begin
            timeout("sat_wait_mst");
            break;
         end
         bus.s_we   = 1'b1;
         bus.s_addr = 7'h40 | 7'(k % 32);
         bus.s_wdat = 32'(k);
         cycle();
         bus.s_we = 1'b0;
      end
      bus.m_req = 1'b0;
      cycle();
      chk("sat_coll", 32'(sm_coll), 255);

      // asynchronous reset in the middle of a master access
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 7'h05;
      bus.s_addr = 7'h44;
      bus.s_wdat = '0;
      w = 0;
      while (md_phase != 1 && w < 30) begin
         cycle();
         w++;
      end
      ok = (md_phase == 1);
      if (!ok)
         timeout("rst_wait_mst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ack", 32'(bus.m_ack), 0);
      chk("arst_rdat", bus.m_rdat, 0);
      chk("arst_own", 32'(spi_own), 0);
      chk("arst_coll", 32'(coll_cnt), 0);
      chk("arst_taddr", 32'(bus.t_addr), 32'h44);
      chk("arst_twe", 32'(bus.t_we), 0);
      @(posedge clk);
      #1;
      chk("arst_noack", 32'(bus.m_ack), 0);
      rst_n = 1'b1;
      model_reset();
      cycle();
      cycle();
      cycle();
      chk("arst_reack", 32'(sm_ack), 1);
      chk("arst_redat", sm_rdat, 32'hDEADBEEF);
      bus.m_req = 1'b0;

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (bus.m_req) begin
            if (sm_ack && $urandom_range(1, 0) == 0)
               bus.m_req = 1'b0;
         end else if ($urandom_range(9, 0) < 3) begin
            bus.m_req  = 1'b1;
            bus.m_we   = 1'($urandom_range(1, 0));
            bus.m_addr = 7'($urandom_range(15, 0));
            bus.m_wdat = $urandom;
         end
         if ($urandom_range(9, 0) == 0)
            bus.s_active = ~bus.s_active;
         bus.s_we   = !bus.s_we && ($urandom_range(7, 0) == 0);
         bus.s_addr = 7'($urandom_range(15, 0));
         bus.s_wdat = $urandom;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
